// File: rtl/team_00_gpio_walker.sv
// Walking-one GPIO pattern generator: an all-zero frame, then a single '1' walks bit 0..WIDTH-1,
// each frame held STEP_CYCLES clocks, repeating while en is high.
module team_00_gpio_walker #(
    parameter int WIDTH       = 34,
    parameter int STEP_CYCLES = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oeb,
    output logic [5:0]       frame,
    output logic             wrap
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [5:0]    FRAME_LAST = 6'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [5:0]       frame_q, frame_d;
    logic [WIDTH-1:0] gpio_q,  gpio_d;
    logic             wrap_q,  wrap_d;

    function automatic logic [WIDTH-1:0] pattern(input logic [5:0] f);
        return (f == 6'd0) ? '0 : (WIDTH'(1) << (f - 6'd1));
    endfunction

    // NOTE: every signal gets a default before the case, so no path leaves a _d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        frame_d = frame_q;
        gpio_d  = gpio_q;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                frame_d = '0;
                gpio_d  = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Dropping en wins over a terminal count on the same edge.
                if (!en) begin
                    state_d = IDLE;
                    presc_d = '0;
                    frame_d = '0;
                    gpio_d  = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + 6'd1;
                    end
                    gpio_d = pattern(frame_d);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                frame_d = '0;
                gpio_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            frame_q <= '0;
            gpio_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            frame_q <= frame_d;
            gpio_q  <= gpio_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gpio_out = gpio_q;
    assign gpio_oeb = '0;
    assign frame    = frame_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_team_00_gpio_walker.sv
// Self-checking bench: two walkers (STEP_CYCLES=4 and 1) against a cycle-count reference model,
// with directed walk/abort/async-reset phases and a randomized enable phase.
module tb_team_00_gpio_walker;

    localparam int W  = 34;
    localparam int S4 = 4;
    localparam int S1 = 1;
    localparam int NF = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b1;

    logic [W-1:0] gpio4, oeb4, gpio1, oeb1;
    logic [5:0]   frame4, frame1;
    logic         wrap4, wrap1;

    int checks = 0;
    int errors = 0;

    team_00_gpio_walker #(.WIDTH(W), .STEP_CYCLES(S4)) dut4 (
        .clk(clk), .rst(rst), .en(en),
        .gpio_out(gpio4), .gpio_oeb(oeb4), .frame(frame4), .wrap(wrap4)
    );

    team_00_gpio_walker #(.WIDTH(W), .STEP_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .gpio_out(gpio1), .gpio_oeb(oeb1), .frame(frame1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    // Reference: count edges since the walk (re)started; everything else is arithmetic on that count.
    bit run;
    int t;
    always @(posedge clk or posedge rst) begin
        if (rst)       begin run <= 1'b0; t <= 0; end
        else if (!en)  begin run <= 1'b0; t <= 0; end
        else if (!run) begin run <= 1'b1; t <= 0; end
        else           t <= t + 1;
    end

    function automatic int exp_frame(int step);
        return run ? (t / step) % NF : 0;
    endfunction

    function automatic logic [W-1:0] exp_gpio(int step);
        int f;
        logic [W-1:0] one;
        f   = exp_frame(step);
        one = 1;
        return (f == 0) ? '0 : (one << (f - 1));
    endfunction

    function automatic logic exp_wrap(int step);
        return run && (t > 0) && (t % (NF * step) == 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic compare_all();
        check("gpio4",  64'(gpio4),  64'(exp_gpio(S4)));
        check("frame4", 64'(frame4), 64'(exp_frame(S4)));
        check("wrap4",  64'(wrap4),  64'(exp_wrap(S4)));
        check("oeb4",   64'(oeb4),   64'd0);
        check("hot4",   64'($onehot0(gpio4)), 64'd1);
        check("gpio1",  64'(gpio1),  64'(exp_gpio(S1)));
        check("frame1", 64'(frame1), 64'(exp_frame(S1)));
        check("wrap1",  64'(wrap1),  64'(exp_wrap(S1)));
        check("oeb1",   64'(oeb1),   64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    int wraps4, wraps1;
    logic [W-1:0] target;

    initial begin
        // Reset held with en=1: outputs zero, no X/Z.
        #2;
        check("rst_gpio", 64'(gpio4), 64'd0);
        check("rst_oeb",  64'(oeb4),  64'd0);
        repeat (3) step();
        check("rst_known", 64'($isunknown({gpio4, oeb4, frame4, wrap4, gpio1, frame1, wrap1})), 64'd0);
        rst = 1'b0;

        // Two complete iterations from a clean start, counting wrap pulses.
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        wraps4 = 0;
        wraps1 = 0;
        for (int i = 0; i < 2 * NF * S4; i++) begin
            step();
            if (wrap4 === 1'b1) wraps4++;
            if (wrap1 === 1'b1) wraps1++;
        end
        check("wraps4_two_iter", 64'(wraps4), 64'd2);
        check("wraps1_two_iter", 64'(wraps1), 64'(2 * NF * S4 / NF));

        // Abort while bit 8 is lit, then restart from the zero frame.
        target = 1;
        target = target << 8;
        for (int i = 0; i < 2 * NF * S4 && gpio4 !== target; i++) step();
        check("reach_0x100", 64'(gpio4), 64'(target));
        en = 1'b0;
        step();
        check("abort_gpio", 64'(gpio4), 64'd0);
        en = 1'b1;
        repeat (S4 + 2) step();

        // Async reset between edges at frame 20.
        for (int i = 0; i < 2 * NF * S4 && frame4 !== 6'd20; i++) step();
        check("reach_f20", 64'(frame4), 64'd20);
        #3 rst = 1'b1;
        #1;
        check("async_gpio",  64'(gpio4),  64'd0);
        check("async_frame", 64'(frame4), 64'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        repeat (3 * S4) step();

        // Randomized enable toggling against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
